// File: rtl/vc_dest_arbiter_pkg.sv
// Shared types and constants for the VC-to-destination weighted round-robin arbiter.
package vc_dest_arbiter_pkg;

    localparam int DATA_W_DEF   = 6;
    localparam int WEIGHT_W_DEF = 4;
    localparam int DEST_BIT_DEF = DATA_W_DEF - 2;

    typedef enum logic {
        TURN_VC0 = 1'b0,
        TURN_VC1 = 1'b1
    } turn_e;

    // Destination-select bit position for a given word width.
    function automatic int dest_bit(input int dw);
        return dw - 2;
    endfunction

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Handshake bundle between the arbiter (master) and the VC/destination FIFOs plus control (slave).
interface vc_dest_arbiter_if #(
    parameter int data_width   = 6,
    parameter int weight_width = 4
);
    logic                    enable;
    logic [weight_width-1:0] weight_vc0;
    logic [weight_width-1:0] weight_vc1;
    logic                    vc0_empty;
    logic                    vc1_empty;
    logic [data_width-1:0]   vc0_data;
    logic [data_width-1:0]   vc1_data;
    logic                    vc0_pop;
    logic                    vc1_pop;
    logic                    d0_almost_full;
    logic                    d1_almost_full;
    logic                    d0_push;
    logic                    d1_push;
    logic [data_width-1:0]   data_out;
    logic                    grant_vc;
    logic                    active;
    logic                    idle;

    modport master (
        input  enable, weight_vc0, weight_vc1,
        input  vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, data_out,
        output grant_vc, active, idle
    );

    modport slave (
        output enable, weight_vc0, weight_vc1,
        output vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, data_out,
        input  grant_vc, active, idle
    );
endinterface

// File: rtl/vc_dest_arbiter_wrr_credit_counter.sv
// Per-turn grant credit: counts grants in the current turn and tells the FSM when to flip turns.
module wrr_credit_counter #(
    parameter int weight_width = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [weight_width-1:0] i_w_own,
    input  logic [weight_width-1:0] i_w_other,
    input  logic                    i_own_pop,
    input  logic                    i_other_pop,
    output logic                    o_switch
);

    logic [weight_width-1:0] r_credit;
    logic [weight_width-1:0] w_credit_nxt;
    logic [weight_width-1:0] w_eff_own;
    logic [weight_width-1:0] w_eff_other;
    logic [weight_width:0]   w_credit_inc;
    logic                    w_turn_done;

    assign w_eff_own    = (i_w_own == '0)   ? weight_width'(1) : i_w_own;
    assign w_eff_other  = (i_w_other == '0) ? weight_width'(1) : i_w_other;
    assign w_credit_inc = {1'b0, r_credit} + (weight_width+1)'(1);
    // >= rather than == so a weight shrunk at re-latch can never strand the counter
    assign w_turn_done  = w_credit_inc >= {1'b0, w_eff_own};

    always_comb begin
        w_credit_nxt = r_credit;
        o_switch     = 1'b0;
        if (i_own_pop) begin
            if (w_turn_done) begin
                w_credit_nxt = '0;
                o_switch     = 1'b1;
            end else begin
                w_credit_nxt = w_credit_inc[weight_width-1:0];
            end
        end else if (i_other_pop) begin
            // A stolen grant counts as the first of the other VC's turn,
            // unless that single grant already exhausts its weight.
            if (w_eff_other == weight_width'(1)) begin
                w_credit_nxt = '0;
            end else begin
                w_credit_nxt = weight_width'(1);
                o_switch     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_credit <= '0;
        else       r_credit <= w_credit_nxt;
    end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin scheduler moving words from VC0/VC1 FIFOs into D0/D1 destination FIFOs.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int data_width   = DATA_W_DEF,
    parameter int weight_width = WEIGHT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    vc_dest_arbiter_if.master bus
);

    localparam int DB = dest_bit(data_width);

    turn_e                   r_state;
    turn_e                   w_state_nxt;
    logic [weight_width-1:0] r_w0;
    logic [weight_width-1:0] r_w1;
    logic                    r_d0_push;
    logic                    r_d1_push;
    logic                    r_idle;
    logic [data_width-1:0]   r_data;

    logic                    w_elig0;
    logic                    w_elig1;
    logic                    w_own_elig;
    logic                    w_other_elig;
    logic                    w_own_pop;
    logic                    w_other_pop;
    logic                    w_pop0;
    logic                    w_pop1;
    logic                    w_pop;
    logic                    w_switch;
    logic [data_width-1:0]   w_pop_word;
    logic [weight_width-1:0] w_w_own;
    logic [weight_width-1:0] w_w_other;

    // Head-of-line: a blocked destination stalls the whole VC.
    assign w_elig0 = bus.enable & ~bus.vc0_empty &
                     ~(bus.vc0_data[DB] ? bus.d1_almost_full : bus.d0_almost_full);
    assign w_elig1 = bus.enable & ~bus.vc1_empty &
                     ~(bus.vc1_data[DB] ? bus.d1_almost_full : bus.d0_almost_full);

    assign w_own_elig   = (r_state == TURN_VC0) ? w_elig0 : w_elig1;
    assign w_other_elig = (r_state == TURN_VC0) ? w_elig1 : w_elig0;
    assign w_own_pop    = ~reset & w_own_elig;
    assign w_other_pop  = ~reset & ~w_own_elig & w_other_elig;

    assign w_pop0     = (r_state == TURN_VC0) ? w_own_pop : w_other_pop;
    assign w_pop1     = (r_state == TURN_VC0) ? w_other_pop : w_own_pop;
    assign w_pop      = w_pop0 | w_pop1;
    assign w_pop_word = w_pop0 ? bus.vc0_data : bus.vc1_data;

    assign w_w_own   = (r_state == TURN_VC0) ? r_w0 : r_w1;
    assign w_w_other = (r_state == TURN_VC0) ? r_w1 : r_w0;

    wrr_credit_counter #(.weight_width(weight_width)) u_credit (
        .clk        (clk),
        .reset      (reset),
        .i_w_own    (w_w_own),
        .i_w_other  (w_w_other),
        .i_own_pop  (w_own_pop),
        .i_other_pop(w_other_pop),
        .o_switch   (w_switch)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= TURN_VC0;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_switch) w_state_nxt = (r_state == TURN_VC0) ? TURN_VC1 : TURN_VC0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0_push <= 1'b0;
            r_d1_push <= 1'b0;
            r_data    <= '0;
            r_idle    <= 1'b0;
            r_w0      <= bus.weight_vc0;
            r_w1      <= bus.weight_vc1;
        end else begin
            r_d0_push <= w_pop & ~w_pop_word[DB];
            r_d1_push <= w_pop &  w_pop_word[DB];
            if (w_pop) r_data <= w_pop_word;
            r_idle <= bus.vc0_empty & bus.vc1_empty & ~w_pop & bus.enable;
            // Weights only move while quiescent so a burst keeps a stable schedule.
            if (r_idle) begin
                r_w0 <= bus.weight_vc0;
                r_w1 <= bus.weight_vc1;
            end
        end
    end

    assign bus.vc0_pop  = w_pop0;
    assign bus.vc1_pop  = w_pop1;
    assign bus.d0_push  = r_d0_push;
    assign bus.d1_push  = r_d1_push;
    assign bus.data_out = r_data;
    assign bus.grant_vc = (r_state == TURN_VC1);
    assign bus.active   = w_pop | r_d0_push | r_d1_push;
    assign bus.idle     = r_idle;

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Weighted round-robin scheduler between the VC0 and VC1 virtual-channel FIFOs and the D0/D1 destination FIFOs of the transmission-layer datapath.
- Each cycle it pops at most one word from one VC FIFO and pushes it one cycle later into D0 or D1, chosen by a destination bit in the word.
- It honours destination almost-full backpressure and reports active/idle status to the top-level state machine.

Parameters:
- data_width, 6, width of data words; bit [data_width-2] selects the destination (0 = D0, 1 = D1).
- weight_width, 4, width of the per-VC weight inputs and of the internal credit counter.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  arbitration allowed; low = no pops, in-flight push still completes.
- weight_vc0  input  weight_width  consecutive grants allowed to VC0 per turn.
- weight_vc1  input  weight_width  consecutive grants allowed to VC1 per turn.
- vc0_empty, vc1_empty  input  1  VC FIFO empty flags.
- vc0_data, vc1_data  input  data_width  FWFT head word, valid while not empty.
- vc0_pop, vc1_pop  output  1  combinational pop strobes; never both high.
- d0_almost_full, d1_almost_full  input  1  destination threshold flags.
- d0_push, d1_push  output  1  registered push strobes; never both high.
- data_out  output  data_width  registered word for the destination FIFO.
- grant_vc  output  1  current turn (0 = VC0, 1 = VC1).
- active  output  1  a pop or push occurred this cycle.
- idle  output  1  both VCs empty, no push pending, enable high.

Behaviour:
- Reset (sync, reset=1): FSM to TURN_VC0, credit=0, d0_push=d1_push=0, data_out=0, grant_vc=0, active=0, idle=0. The latched weights load from the inputs. Pops are forced to 0 while reset is high.
- Eligibility of VCx: enable=1, vcx_empty=0, and the head's destination almost_full=0.
- Effective weight: latched weight, with 0 treated as 1. Weights re-latch on every cycle idle=1 and on reset; a changed input mid-burst has no effect until then.
- FSM states: TURN_VC0, TURN_VC1. grant_vc = state.
- In TURN_x with VCx eligible: assert vcx_pop and credit++.
  - If credit+1 == effective weight_x, go to the other turn next cycle and set credit=0.
- In TURN_x with VCx not eligible and the other VC eligible: pop the other VC this same cycle (work-conserving). Go to the other turn and set credit=1.
  - If the other VC's weight is 1, this instead returns to TURN_x with credit=0.
- Neither VC eligible: no pop; state and credit hold.
- Latency: pop in cycle N; at edge N+1, data_out = popped word, and d0_push or d1_push = 1 for cycle N+1 only. No further latency.
- Back-to-back: one pop every cycle is allowed; pushes follow with a 1-cycle lag.
- Almost-full is sampled in the pop cycle. The destination's threshold must leave at least 1 slot of slack for the in-flight word.
- Head-of-line: a blocked destination blocks its whole VC. Words within a VC are never reordered.
- enable drops mid-burst: pops stop immediately; a pending push still issues next cycle; state and credit hold.
- active = any pop or push this cycle (combinational).
- idle = registered: vc0_empty & vc1_empty & no pop this cycle & enable.

Decomposition:
- Shared package: FSM state encoding (TURN_VC0/TURN_VC1), the destination-bit index constant data_width-2, and the default widths.
- One natural sub-module: wrr_credit_counter (credit register, effective-weight compare, turn-done output), instantiated once.
- Pop/push steering and status stay in the top module.

Test Plan:
- Reset held 4 cycles with VC FIFOs preloaded -> no pops, all outputs 0. First pop occurs the cycle after reset falls, from VC0.
- weight_vc0=2, weight_vc1=1, 6 words in each VC, all destination D0 -> pop order VC0,VC0,VC1,VC0,VC0,VC1,... Each word is on data_out with d0_push=1 exactly 1 cycle after its pop.
- VC0 words 6'b000001 to 6'b000100 (dest D0), VC1 words 6'b010001 onward (dest D1), weights 1/1 -> alternating pops. Pushes go to D0 for VC0 words and to D1 for VC1 words.
- d1_almost_full=1 while VC1's head targets D1 and VC0 holds 3 words -> VC0 is popped every cycle with no VC1 pop. Releasing the flag resumes VC1 on the next cycle.
- enable dropped 1 cycle after a pop -> the pending push still occurs and no new pop happens. Re-raising enable resumes in the same turn with credit preserved.
- Both VCs drained -> idle=1 on the next cycle and weights re-latch. Setting weight_vc0=0 then gives 1 grant per VC0 turn.
